// File: rtl/rs_enc_arbiter.sv
// Per-packet round-robin arbiter sharing one RS encoder between two voice-frame
// sources, with Avalon-ST sop/eop framing and a single registered output stage.
module rs_enc_arbiter #(
  parameter int unsigned DATA_W    = 80,
  parameter int unsigned PKT_BEATS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              enc_ready,
  output logic              enc_valid,
  output logic              enc_startofpacket,
  output logic              enc_endofpacket,
  output logic [DATA_W-1:0] enc_data,
  output logic              grant_id,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam logic [7:0] LAST_BEAT = 8'(PKT_BEATS - 1);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic [7:0]         beat_q, beat_d;
  logic               enc_valid_q, enc_valid_d;
  logic               enc_sop_q, enc_sop_d;
  logic               enc_eop_q, enc_eop_d;
  logic [DATA_W-1:0]  enc_data_q, enc_data_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic               load_ok;
  logic               src_valid;
  logic               src_hs;
  logic [DATA_W-1:0]  src_data;

  // Arbitration and beat sequencing
  always_comb begin
    load_ok   = !enc_valid_q || enc_ready;
    src_valid = grant_q ? s1_valid : s0_valid;
    src_data  = grant_q ? s1_data : s0_data;
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    beat_d    = beat_q;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    src_hs    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          if (s0_valid && s1_valid) begin
            grant_d = ~last_q;
          end else begin
            grant_d = s1_valid;
          end
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // Readies are masked during reset so no beat is taken and then discarded.
        s0_ready = !reset_reset && !grant_q && load_ok;
        s1_ready = !reset_reset && grant_q && load_ok;
        src_hs   = load_ok && src_valid;
        if (src_hs) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == LAST_BEAT) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register stage: drains independently of the FSM state
  always_comb begin
    enc_valid_d = enc_valid_q;
    enc_sop_d   = enc_sop_q;
    enc_eop_d   = enc_eop_q;
    enc_data_d  = enc_data_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (enc_valid_q && enc_ready) begin
      enc_valid_d = 1'b0;
      enc_sop_d   = 1'b0;
      enc_eop_d   = 1'b0;
      if (enc_eop_q) begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end
    end

    if (src_hs) begin
      enc_valid_d = 1'b1;
      enc_data_d  = src_data;
      enc_sop_d   = (beat_q == '0);
      enc_eop_d   = (beat_q == LAST_BEAT);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      beat_q      <= '0;
      enc_valid_q <= 1'b0;
      enc_sop_q   <= 1'b0;
      enc_eop_q   <= 1'b0;
      enc_data_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      enc_valid_q <= enc_valid_d;
      enc_sop_q   <= enc_sop_d;
      enc_eop_q   <= enc_eop_d;
      enc_data_q  <= enc_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign enc_valid         = enc_valid_q;
  assign enc_startofpacket = enc_sop_q;
  assign enc_endofpacket   = enc_eop_q;
  assign enc_data          = enc_data_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q == SEND);
  assign pkt_count         = pkt_cnt_q;

endmodule
